// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready pipeline stage with a skid register and fully registered I_READY.
// Optional simulation X/Z checker: define PIPE_SKID_BUF_XCHECK_EN (ignored when SYNTHESIS is defined).
//
// Handshake: a beat moves on a rising CLK edge when valid and ready are both high on that side;
// a producer holds valid/data until the beat moves, and ready never depends combinationally on valid.
module pipe_skid_buf #(
    parameter int Width = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [Width-1:0] I_DATA,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [Width-1:0] O_DATA
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       dbg_state;
    logic             in_rdy_q;
    logic [Width-1:0] main_q;
    logic [Width-1:0] skid_q;
    logic             xfer_in;
    logic             xfer_out;
    logic             load_main;
    logic             main_from_skid;
    logic             load_skid;

    assign dbg_state = state;
    assign O_VALID   = (state != ST_EMPTY);
    assign I_READY   = in_rdy_q;
    assign O_DATA    = main_q;
    assign xfer_in   = I_VALID & in_rdy_q;
    assign xfer_out  = O_VALID & O_READY;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (xfer_in) begin
                    load_main = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                case ({xfer_in, xfer_out})
                    2'b11: load_main = 1'b1;
                    2'b10: begin
                        load_skid = 1'b1;
                        state_nxt = ST_FULL;
                    end
                    2'b01: state_nxt = ST_EMPTY;
                    default: state_nxt = ST_BUSY;
                endcase
            end
            ST_FULL: begin
                // I_READY is low here, so only the skid-to-main move can happen.
                if (xfer_out) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = ST_BUSY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_EMPTY;
            in_rdy_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_rdy_q <= (state_nxt != ST_FULL);
        end
    end

    // Payload registers carry no reset; contents are meaningless while not marked valid.
    always_ff @(posedge CLK) begin
        if (load_main) begin
            main_q <= main_from_skid ? skid_q : I_DATA;
        end
        if (load_skid) begin
            skid_q <= I_DATA;
        end
    end

`ifdef PIPE_SKID_BUF_XCHECK_EN
`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if ($isunknown(RST)) begin
            $error("pipe_skid_buf: X/Z on RST");
        end else if (!RST) begin
            if ($isunknown(I_VALID)) $error("pipe_skid_buf: X/Z on I_VALID");
            if ($isunknown(O_READY)) $error("pipe_skid_buf: X/Z on O_READY");
            if (I_VALID === 1'b1 && $isunknown(I_DATA)) $error("pipe_skid_buf: X/Z on I_DATA");
            if (O_VALID === 1'b1 && $isunknown(O_DATA)) $error("pipe_skid_buf: X/Z on O_DATA");
        end
    end
`endif
`endif

endmodule
